led_frame_sched: RTL

- Frame-level controller in front of fifo_fsm (8-zone, 4-bit-per-channel mean colours → LED FIFO → serializer).
- Freezes one set of zone means per frame, picks the source (video means or built-in fallback) and pulses fifo_fsm start.
- Waits for the serializer's send_done, enforces the LED latch gap, then paces the next frame from a free-running frame timer.

---
 rtl/led_pkg.sv | 29 ++
 rtl/led_tick_timer.sv | 31 +++
 rtl/led_frame_sched.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types for the LED frame scheduler: zone geometry, colour payload, FSM states.
package led_pkg;

   localparam int unsigned ZONES = 8;
   localparam int unsigned CW    = 4;
   localparam int unsigned ZW    = ZONES * CW;

   // One frame's worth of per-zone means, zone i at [CW*i +: CW] of each field.
   typedef struct packed {
      logic [ZW-1:0] r;
      logic [ZW-1:0] g;
      logic [ZW-1:0] b;
   } zone_rgb_t;

   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      SNAP,
      START,
      WAIT_DONE,
      LATCH
   } sched_state_t;

   // Replicate one channel value across every zone.
   function automatic logic [ZW-1:0] fill_zones(input logic [CW-1:0] c);
      return {ZONES{c}};
   endfunction

endpackage

// File: rtl/led_tick_timer.sv
// Reloadable down-counter: o_done_c flags the last cycle of a CYCLES-long run.
module led_tick_timer #(
   parameter int unsigned CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_en,
   output logic o_done_c
);

   localparam int unsigned W   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [W-1:0] TOP = W'(CYCLES - 1);

   // TOP means "no cycles elapsed yet"; the count wraps back to TOP after done.
   logic [W-1:0] r_cnt;

   // Count down while enabled, restart on load or after reaching zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= TOP;
      end else if (i_load) begin
         r_cnt <= TOP;
      end else if (i_en) begin
         r_cnt <= (r_cnt == '0) ? TOP : r_cnt - W'(1);
      end
   end

   assign o_done_c = i_en && (r_cnt == '0);

endmodule

// File: rtl/led_frame_sched.sv
// Frame-level scheduler in front of fifo_fsm: snapshots zone means once per frame,
// chooses video or fallback colour, pulses start, waits for send_done and the latch gap.
module led_frame_sched
   import led_pkg::*;
#(
   parameter int unsigned FRAME_CYCLES   = 833333,
   parameter int unsigned LATCH_CYCLES   = 15000,
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter int unsigned STALE_FRAMES   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            vid_valid,
   input  logic [ZW-1:0]   vid_r,
   input  logic [ZW-1:0]   vid_g,
   input  logic [ZW-1:0]   vid_b,
   input  logic [3*CW-1:0] fb_rgb,
   input  logic            send_done,
   output logic            fsm_en,
   output logic            fsm_start,
   output logic [ZW-1:0]   mean_r,
   output logic [ZW-1:0]   mean_g,
   output logic [ZW-1:0]   mean_b,
   output logic            src_fb,
   output logic            busy,
   output logic            err_timeout,
   output logic [15:0]     frame_cnt
);

   localparam int unsigned SW = (STALE_FRAMES > 0) ? $clog2(STALE_FRAMES + 1) : 1;
   localparam logic [SW-1:0] STALE_MAX = SW'(STALE_FRAMES);

   sched_state_t  r_state;
   sched_state_t  w_next;
   logic          w_timeout_hit;
   logic          w_busy_next;

   zone_rgb_t     r_shadow;
   zone_rgb_t     r_mean;
   logic          r_new;
   logic [SW-1:0] r_stale;

   logic          r_fsm_en;
   logic          r_fsm_start;
   logic          r_src_fb;
   logic          r_busy;
   logic          r_err;
   logic [15:0]   r_frame_cnt;

   logic          w_tick;
   logic          w_latch_done;
   logic          w_to_done;
   logic          w_to_run;

   assign w_to_run = (r_state == START) || (r_state == WAIT_DONE);

   // Frame pacing: held at its start value while disabled, free-runs otherwise.
   led_tick_timer #(.CYCLES(FRAME_CYCLES)) u_frame_tmr (
      .clk      (clk),
      .rst      (rst),
      .i_load   (!en),
      .i_en     (en),
      .o_done_c (w_tick)
   );

   // Idle gap after the serializer finishes, armed while waiting for send_done.
   led_tick_timer #(.CYCLES(LATCH_CYCLES)) u_latch_tmr (
      .clk      (clk),
      .rst      (rst),
      .i_load   (r_state != LATCH),
      .i_en     (r_state == LATCH),
      .o_done_c (w_latch_done)
   );

   // send_done watchdog, counted from the start pulse.
   led_tick_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout_tmr (
      .clk      (clk),
      .rst      (rst),
      .i_load   (!w_to_run),
      .i_en     (w_to_run),
      .o_done_c (w_to_done)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode; ticks seen outside HOLD are simply dropped.
   always_comb begin
      w_next        = r_state;
      w_timeout_hit = 1'b0;
      case (r_state)
         IDLE:      if (en) w_next = HOLD;
         HOLD: begin
            if (!en)        w_next = IDLE;
            else if (w_tick) w_next = SNAP;
         end
         SNAP:      w_next = START;
         START:     w_next = WAIT_DONE;
         WAIT_DONE: begin
            if (send_done) begin
               w_next = LATCH;
            end else if (w_to_done) begin
               w_next        = LATCH;
               w_timeout_hit = 1'b1;
            end
         end
         LATCH:     if (w_latch_done) w_next = en ? HOLD : IDLE;
         default:   w_next = IDLE;
      endcase
      w_busy_next = (w_next == SNAP) || (w_next == START) ||
                    (w_next == WAIT_DONE) || (w_next == LATCH);
   end

   // Control outputs registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm_en    <= 1'b0;
         r_fsm_start <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_frame_cnt <= 16'd0;
      end else begin
         r_fsm_en    <= (w_next != IDLE);
         r_fsm_start <= (w_next == START);
         r_busy      <= w_busy_next;
         if (w_next == START) r_frame_cnt <= r_frame_cnt + 16'd1;
         if (w_timeout_hit)   r_err       <= 1'b1;
      end
   end

   // Shadow capture on any vid_valid; a strobe during SNAP is kept for the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow <= '0;
         r_new    <= 1'b0;
      end else begin
         if (vid_valid) r_shadow <= '{r: vid_r, g: vid_g, b: vid_b};
         if (vid_valid)             r_new <= 1'b1;
         else if (r_state == SNAP)  r_new <= 1'b0;
      end
   end

   // Source selection: fresh video, repeat of last frame, or fallback once stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mean   <= '0;
         r_stale  <= '0;
         r_src_fb <= 1'b0;
      end else if (r_state == SNAP) begin
         if (r_new) begin
            r_mean   <= r_shadow;
            r_stale  <= '0;
            r_src_fb <= 1'b0;
         end else begin
            if (r_stale >= STALE_MAX) begin
               r_mean.r <= fill_zones(fb_rgb[3*CW-1:2*CW]);
               r_mean.g <= fill_zones(fb_rgb[2*CW-1:CW]);
               r_mean.b <= fill_zones(fb_rgb[CW-1:0]);
               r_src_fb <= 1'b1;
            end
            if (r_stale < STALE_MAX) r_stale <= r_stale + SW'(1);
         end
      end
   end

   assign fsm_en      = r_fsm_en;
   assign fsm_start   = r_fsm_start;
   assign mean_r      = r_mean.r;
   assign mean_g      = r_mean.g;
   assign mean_b      = r_mean.b;
   assign src_fb      = r_src_fb;
   assign busy        = r_busy;
   assign err_timeout = r_err;
   assign frame_cnt   = r_frame_cnt;

endmodule
